bsg_cache_dma_wh_sequencer: RTL and testbench

Sequences one cache DMA request into the cache-DMA wormhole flit stream: header, address, optional mask, then data flits. Sits between a single cache's DMA interface (packet channel plus evict-data channel) and the wormhole link toward memory. Selects the wormhole opcode and length from the request type and mask, then paces the data flits under link backpressure.

---
 rtl/bsg_cache_dma_wh_sequencer_if.sv | 39 +++
 rtl/bsg_cache_dma_wh_sequencer.sv | 141 ++++++++++++++
 tb/tb_bsg_cache_dma_wh_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bsg_cache_dma_wh_sequencer_if.sv
// Bundle of cache-DMA request/data channels and the wormhole link driven by the sequencer.
// The master modport is the sequencer side; slave is the cache/link side.
interface bsg_cache_dma_wh_sequencer_if #(
    parameter int addr_width_p          = 32,
    parameter int flit_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int cord_width_p          = 8,
    parameter int src_id_width_p        = 4
);
    logic                             dma_pkt_v_i;
    logic                             dma_pkt_write_not_read_i;
    logic                             dma_pkt_io_i;
    logic                             dma_pkt_masked_i;
    logic [block_size_in_words_p-1:0] dma_pkt_mask_i;
    logic [addr_width_p-1:0]          dma_pkt_addr_i;
    logic                             dma_pkt_yumi_o;
    logic [cord_width_p-1:0]          dest_cord_i;
    logic [src_id_width_p-1:0]        src_id_i;
    logic [flit_width_p-1:0]          dma_data_i;
    logic                             dma_data_v_i;
    logic                             dma_data_yumi_o;
    logic [flit_width_p-1:0]          flit_o;
    logic                             v_o;
    logic                             ready_i;

    modport master (
        input  dma_pkt_v_i, dma_pkt_write_not_read_i, dma_pkt_io_i, dma_pkt_masked_i,
               dma_pkt_mask_i, dma_pkt_addr_i, dest_cord_i, src_id_i,
               dma_data_i, dma_data_v_i, ready_i,
        output dma_pkt_yumi_o, dma_data_yumi_o, flit_o, v_o
    );

    modport slave (
        output dma_pkt_v_i, dma_pkt_write_not_read_i, dma_pkt_io_i, dma_pkt_masked_i,
               dma_pkt_mask_i, dma_pkt_addr_i, dest_cord_i, src_id_i,
               dma_data_i, dma_data_v_i, ready_i,
        input  dma_pkt_yumi_o, dma_data_yumi_o, flit_o, v_o
    );
endinterface

// File: rtl/bsg_cache_dma_wh_sequencer.sv
// Turns one cache DMA request into header, address, optional mask and data flits
// on the wormhole link, pacing data words under link backpressure.
module bsg_cache_dma_wh_sequencer #(
    parameter int addr_width_p          = 32,
    parameter int flit_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int len_width_p           = 4,
    parameter int cord_width_p          = 8,
    parameter int src_id_width_p        = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_cache_dma_wh_sequencer_if.master bus
);
    localparam int cnt_width_lp = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;

    localparam logic [2:0] OP_READ         = 3'b000;
    localparam logic [2:0] OP_VALIDATE     = 3'b001;
    localparam logic [2:0] OP_WRITE        = 3'b010;
    localparam logic [2:0] OP_WRITE_MASKED = 3'b011;
    localparam logic [2:0] OP_IO_READ      = 3'b100;
    localparam logic [2:0] OP_IO_WRITE     = 3'b101;

    localparam logic [len_width_p-1:0] LEN_ONE    = len_width_p'(1);
    localparam logic [len_width_p-1:0] LEN_TWO    = len_width_p'(2);
    localparam logic [len_width_p-1:0] LEN_FULL   = len_width_p'(1 + block_size_in_words_p);
    localparam logic [len_width_p-1:0] LEN_MASKED = len_width_p'(2 + block_size_in_words_p);
    localparam logic [cnt_width_lp-1:0] CNT_LAST  = cnt_width_lp'(block_size_in_words_p - 1);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_ADDR, S_MASK, S_DATA} state_e;

    state_e                           r_state, w_state_next;
    logic [2:0]                       r_opcode, w_opcode;
    logic [len_width_p-1:0]           r_len, w_len;
    logic [addr_width_p-1:0]          r_addr;
    logic [block_size_in_words_p-1:0] r_mask;
    logic [cord_width_p-1:0]          r_dest;
    logic [src_id_width_p-1:0]        r_src;
    logic [cnt_width_lp-1:0]          r_count;
    logic [flit_width_p-1:0]          w_header, w_flit;
    logic                             w_v, w_accept, w_data_yumi, w_last_word, w_has_data;

    // Opcode decode; an all-zero mask degenerates to a validate with no data at all.
    always_comb begin
        w_opcode = OP_READ;
        w_len    = LEN_ONE;
        if (!bus.dma_pkt_write_not_read_i) begin
            w_opcode = bus.dma_pkt_io_i ? OP_IO_READ : OP_READ;
        end else if (bus.dma_pkt_io_i) begin
            w_opcode = OP_IO_WRITE;
            w_len    = LEN_TWO;
        end else if (bus.dma_pkt_masked_i && (bus.dma_pkt_mask_i == '0)) begin
            w_opcode = OP_VALIDATE;
        end else if (bus.dma_pkt_masked_i && !(&bus.dma_pkt_mask_i)) begin
            w_opcode = OP_WRITE_MASKED;
            w_len    = LEN_MASKED;
        end else begin
            w_opcode = OP_WRITE;
            w_len    = LEN_FULL;
        end
    end

    always_comb begin
        w_header = '0;
        w_header[cord_width_p-1:0]                               = r_dest;
        w_header[cord_width_p +: len_width_p]                    = r_len;
        w_header[cord_width_p+len_width_p +: 3]                  = r_opcode;
        w_header[cord_width_p+len_width_p+3 +: src_id_width_p]   = r_src;
    end

    assign w_has_data  = (r_opcode == OP_WRITE) || (r_opcode == OP_WRITE_MASKED)
                      || (r_opcode == OP_IO_WRITE);
    assign w_last_word = (r_opcode == OP_IO_WRITE) ? (r_count == '0) : (r_count == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_data_yumi  = 1'b0;
        w_v          = 1'b0;
        w_flit       = '0;
        unique case (r_state)
            S_IDLE: begin
                w_accept = bus.dma_pkt_v_i & ~reset_i;
                if (bus.dma_pkt_v_i) w_state_next = S_HEADER;
            end
            S_HEADER: begin
                w_v    = 1'b1;
                w_flit = w_header;
                if (bus.ready_i) w_state_next = S_ADDR;
            end
            S_ADDR: begin
                w_v    = 1'b1;
                w_flit = flit_width_p'(r_addr);
                if (bus.ready_i) begin
                    if (r_opcode == OP_WRITE_MASKED) w_state_next = S_MASK;
                    else if (w_has_data)             w_state_next = S_DATA;
                    else                             w_state_next = S_IDLE;
                end
            end
            S_MASK: begin
                w_v    = 1'b1;
                w_flit = flit_width_p'(r_mask);
                if (bus.ready_i) w_state_next = S_DATA;
            end
            S_DATA: begin
                w_v         = bus.dma_data_v_i;
                w_flit      = bus.dma_data_i;
                w_data_yumi = bus.dma_data_v_i & bus.ready_i;
                if (w_data_yumi && w_last_word) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.dma_pkt_yumi_o  = w_accept;
    assign bus.dma_data_yumi_o = w_data_yumi;
    assign bus.v_o             = w_v;
    assign bus.flit_o          = w_flit;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_data_yumi) r_count <= w_last_word ? '0 : r_count + cnt_width_lp'(1);
        end
    end

    // Request fields are only captured on accept, so they hold for the whole packet.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_opcode <= w_opcode;
            r_len    <= w_len;
            r_addr   <= bus.dma_pkt_addr_i;
            r_mask   <= bus.dma_pkt_mask_i;
            r_dest   <= bus.dest_cord_i;
            r_src    <= bus.src_id_i;
        end
    end
endmodule

// File: tb/tb_bsg_cache_dma_wh_sequencer.sv
// Bench for the cache DMA wormhole sequencer: directed and random packets compared
// against an expected flit list built from the request type and mask.
module tb_bsg_cache_dma_wh_sequencer;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] words [N];

    always #5 clk = ~clk;

    bsg_cache_dma_wh_sequencer_if #(
        .addr_width_p(32), .flit_width_p(32), .block_size_in_words_p(N),
        .cord_width_p(8), .src_id_width_p(4)
    ) bus ();

    bsg_cache_dma_wh_sequencer #(
        .addr_width_p(32), .flit_width_p(32), .block_size_in_words_p(N),
        .len_width_p(4), .cord_width_p(8), .src_id_width_p(4)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic randomize_pkt_inputs();
        bus.dma_pkt_write_not_read_i = 1'($urandom_range(0, 1));
        bus.dma_pkt_io_i             = 1'($urandom_range(0, 1));
        bus.dma_pkt_masked_i         = 1'($urandom_range(0, 1));
        bus.dma_pkt_mask_i           = 8'($urandom());
        bus.dma_pkt_addr_i           = $urandom();
        bus.dest_cord_i              = 8'($urandom());
        bus.src_id_i                 = 4'($urandom());
    endtask

    // rdy_mode: 0 ready always high, 1 random, 2 three-cycle stalls on header and data word 4.
    // abort_at: flit index at which reset is asserted mid-packet (-1 for none).
    task automatic run_pkt(input logic wr, input logic io, input logic masked,
                           input logic [7:0] mask, input logic [31:0] addr,
                           input logic [7:0] dest, input logic [3:0] src,
                           input logic [31:0] first_word, input int rdy_mode,
                           input bit dv_rand, input int abort_at);
        logic [31:0] body[$];
        logic [31:0] exp[$];
        int op, ndata, nd, nf, idx, cyc, low_left;
        bit hdr_stall_done, data_stall_done;
        logic rdy, dv;

        for (int i = 0; i < N; i++) words[i] = $urandom();
        words[0] = first_word;

        // Expected flit list: everything after the header is counted by len.
        ndata = 0;
        body.push_back(addr);
        if (!wr)                            op = io ? 4 : 0;
        else if (io)                      begin op = 5; ndata = 1; end
        else if (masked && mask == 8'h00)   op = 1;
        else if (masked && mask != 8'hFF) begin op = 3; ndata = N; body.push_back({24'h0, mask}); end
        else                              begin op = 2; ndata = N; end
        for (int i = 0; i < ndata; i++) body.push_back(words[i]);
        exp.push_back(32'(dest) + (32'(body.size()) << 8) + (32'(op) << 12) + (32'(src) << 15));
        foreach (body[i]) exp.push_back(body[i]);
        nf = exp.size();
        nd = nf - ndata;

        @(negedge clk);
        bus.dma_pkt_v_i = 1'b1;
        bus.dma_pkt_write_not_read_i = wr;
        bus.dma_pkt_io_i = io;
        bus.dma_pkt_masked_i = masked;
        bus.dma_pkt_mask_i = mask;
        bus.dma_pkt_addr_i = addr;
        bus.dest_cord_i = dest;
        bus.src_id_i = src;
        bus.ready_i = 1'b1;
        bus.dma_data_v_i = 1'b0;
        #1;
        check("accept_yumi", 32'(bus.dma_pkt_yumi_o), 32'd1);
        check("accept_v", 32'(bus.v_o), 32'd0);

        idx = 0; cyc = 0; low_left = 0;
        hdr_stall_done = 0; data_stall_done = 0;
        while (idx < nf && cyc < 300) begin
            if (abort_at >= 0 && idx == abort_at) break;
            @(negedge clk);
            bus.dma_pkt_v_i = 1'($urandom_range(0, 1));
            randomize_pkt_inputs();
            case (rdy_mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!hdr_stall_done && idx == 0) begin low_left = 3; hdr_stall_done = 1; end
                    if (!data_stall_done && idx == nd + 4) begin low_left = 3; data_stall_done = 1; end
                    rdy = (low_left == 0);
                    if (low_left > 0) low_left--;
                end
            endcase
            dv = dv_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.ready_i = rdy;
            bus.dma_data_v_i = dv;
            bus.dma_data_i = (idx >= nd) ? words[idx - nd] : $urandom();
            #1;
            check("v_o", 32'(bus.v_o), (idx < nd) ? 32'd1 : 32'(dv));
            if ((idx < nd) || dv) check("flit", bus.flit_o, exp[idx]);
            check("pkt_yumi_busy", 32'(bus.dma_pkt_yumi_o), 32'd0);
            check("data_yumi", 32'(bus.dma_data_yumi_o), 32'((idx >= nd) && dv && rdy));
            if (((idx < nd) || dv) && rdy) idx++;
            cyc++;
        end

        if (abort_at >= 0) begin
            @(negedge clk);
            reset = 1'b1;
            bus.dma_pkt_v_i = 1'b0;
            bus.ready_i = 1'b1;
            bus.dma_data_v_i = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            #1;
            check("abort_v", 32'(bus.v_o), 32'd0);
            check("abort_data_yumi", 32'(bus.dma_data_yumi_o), 32'd0);
            check("abort_pkt_yumi", 32'(bus.dma_pkt_yumi_o), 32'd0);
            $display("pkt op=%0d aborted after %0d of %0d flits", op, idx, nf);
            return;
        end

        check("all_flits", 32'(idx), 32'(nf));
        if (rdy_mode == 0 && !dv_rand) check("latency", 32'(cyc), 32'(nf));

        @(negedge clk);
        bus.dma_pkt_v_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.dma_data_v_i = 1'b1;
        #1;
        check("idle_v", 32'(bus.v_o), 32'd0);
        check("idle_pkt_yumi", 32'(bus.dma_pkt_yumi_o), 32'd0);
        check("idle_data_yumi", 32'(bus.dma_data_yumi_o), 32'd0);
        $display("pkt op=%0d len=%0d flits=%0d cycles=%0d", op, nf - 1, idx, cyc);
    endtask

    initial begin
        reset = 1'b1;
        bus.dma_pkt_v_i = 1'b0;
        randomize_pkt_inputs();
        bus.dma_data_i = '0;
        bus.dma_data_v_i = 1'b0;
        bus.ready_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_v", 32'(bus.v_o), 32'd0);
        check("reset_pkt_yumi", 32'(bus.dma_pkt_yumi_o), 32'd0);
        check("reset_data_yumi", 32'(bus.dma_data_yumi_o), 32'd0);

        // Directed cases
        run_pkt(1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_1000, 8'h05, 4'h3, $urandom(), 0, 0, -1);
        run_pkt(1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_2000, 8'h11, 4'h2, $urandom(), 0, 0, -1);
        run_pkt(1'b1, 1'b0, 1'b1, 8'h0F, 32'h0000_3000, 8'h22, 4'h1, $urandom(), 0, 0, -1);
        run_pkt(1'b1, 1'b0, 1'b1, 8'hFF, 32'h0000_3000, 8'h22, 4'h1, $urandom(), 0, 0, -1);
        run_pkt(1'b1, 1'b0, 1'b1, 8'h00, 32'h0000_3000, 8'h22, 4'h1, $urandom(), 0, 0, -1);
        run_pkt(1'b1, 1'b1, 1'b0, 8'h00, 32'h0000_4004, 8'h33, 4'h7, 32'hDEAD_BEEF, 0, 0, -1);
        run_pkt(1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_5000, 8'h44, 4'h6, $urandom(), 0, 0, -1);
        run_pkt(1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_6008, 8'h55, 4'h5, $urandom(), 0, 0, -1);
        run_pkt(1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_7000, 8'h66, 4'h4, $urandom(), 2, 1, -1);
        run_pkt(1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_8000, 8'h77, 4'h9, $urandom(), 0, 0, 5);
        run_pkt(1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_9000, 8'h05, 4'h3, $urandom(), 0, 0, -1);

        // Random packets under random backpressure and data gaps
        for (int k = 0; k < 40; k++) begin
            logic [7:0] m;
            case ($urandom_range(0, 3))
                0: m = 8'h00;
                1: m = 8'hFF;
                default: m = 8'($urandom());
            endcase
            run_pkt(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    m, $urandom(), 8'($urandom()), 4'($urandom()), $urandom(),
                    (k % 4 == 0) ? 0 : 1, (k % 4 != 0), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
